life_run_ctrl: RTL and testbench
================================

Name: life_run_ctrl

Overview:
Sequencing controller for the 8x8 Game-of-Life generation datapath (64-bit grid in, next-generation grid out).
- Owns the current-grid register and loads it from a seed.
- Advances it one generation at a time at a programmable pace, or single-steps while paused.
- Stops on stable, extinct, or generation-limit conditions and reports status to the top level and display.

Parameters:
WIDTH, 64, grid width in bits; bit index = 8*row + col.
TICK_DIV, 4, clock cycles per generation in RUN mode (>=1).
GEN_W, 16, width of generation counter and limit.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
seed  in  WIDTH  initial pattern, sampled on load.
load  in  1  1-cycle pulse: copy seed into grid.
clear  in  1  synchronous clear of grid and status.
run  in  1  level: 1 = free-run, 0 = pause.
step  in  1  1-cycle pulse: advance one generation while paused.
gen_limit  in  GEN_W  stop after this many generations; 0 = unlimited.
next_grid  in  WIDTH  datapath next-generation output; combinational function of cur_grid.
cur_grid  out  WIDTH  current grid, drives the datapath input and the display.
gen_count  out  GEN_W  generations committed since load.
step_en  out  1  high in the cycle whose clock edge commits an update.
busy  out  1  high in RUN.
done  out  1  high in DONE.
stable  out  1  sticky: stopped because next_grid == cur_grid.
extinct  out  1  sticky: grid became or was all zero.

Behaviour:
- Reset (async, any state): state IDLE, cur_grid=0, gen_count=0, tick=0; step_en, busy, done, stable and extinct all 0.
- Priority every cycle: clear > load > run/step logic.
- clear: cur_grid=0, gen_count=0, tick=0, stable and extinct cleared, next state IDLE.
- load: cur_grid=seed, gen_count=0, tick=0, flags cleared, next state PAUSE. Legal from any state, including mid-RUN.
- States: IDLE, PAUSE, RUN, DONE.
- IDLE: run and step are ignored; only load leaves.
- PAUSE:
  - run=1 -> RUN with tick=0.
  - step=1 -> one update event this cycle; stays PAUSE unless a halt occurs.
  - If run and step are both 1, run wins and step is dropped.
- RUN:
  - tick counts 0..TICK_DIV-1. An update event occurs in the cycle tick==TICK_DIV-1, then tick returns to 0.
  - With TICK_DIV=1 an update occurs every cycle.
  - run=0 -> PAUSE, tick=0, no update that cycle.
- DONE: done=1. run and step are ignored; only load, clear or reset leave.
- Update event, evaluated in priority order; step_en=1 that cycle in every case:
  1. next_grid==0:
     - cur_grid <= 0.
     - gen_count increments only if cur_grid != 0.
     - extinct <= 1, state -> DONE.
  2. next_grid==cur_grid: no commit, no increment, stable <= 1, state -> DONE.
  3. Otherwise: cur_grid <= next_grid, gen_count+1.
     - If gen_limit != 0 and the new count == gen_limit, state -> DONE with stable=0 and extinct=0.
- gen_count saturates at all-ones.
- The gen_limit compare uses the live input at update time. Lowering gen_limit below gen_count never matches, so the run continues.
- Oscillators (period >= 2) are not detected; they halt only via gen_limit.
- busy = (state==RUN). done = (state==DONE). All outputs are registered except step_en, busy and done, which are decoded from state and tick.
- Update latency: cur_grid reflects next_grid on the clock edge ending the step_en cycle. In RUN the first update occurs TICK_DIV cycles after entering RUN.

Test Plan:
Bench drives next_grid from a golden Life model of cur_grid (dead boundary); TICK_DIV=4.
1. Reset mid-RUN:
   - Load 0x0000_0000_0404_0400, run=1, assert reset asynchronously between edges.
   - Outputs go to 0 immediately, state IDLE; run is ignored until the next load.
2. Blinker with limit:
   - Load 0x0000_0000_0404_0400, gen_limit=4, run=1.
   - cur_grid alternates 0x000E_0000 / 0x0404_0400, one update every 4 cycles.
   - After 4 updates: done=1, gen_count=4, grid=0x0404_0400, stable=0.
3. Still life:
   - Load block 0x0006_0600, run=1.
   - First update event: stable=1, done=1, gen_count=0, step_en pulses once, grid unchanged.
4. Extinction with single-step:
   - Load 0x0000_0000_0000_0200, keep run=0, pulse step.
   - Next cycle: cur_grid=0, gen_count=1, extinct=1, done=1; further step or run has no effect.
5. Pause/resume and collisions:
   - Blinker, run=1 for 6 cycles, then run=0: gen_count=1, tick cleared.
   - step and run together in PAUSE: enters RUN, no immediate update.
   - load during DONE: returns to PAUSE with flags cleared.
   - clear and load in the same cycle: grid=0, state IDLE.

Source files
------------

// File: rtl/life_run_ctrl_if.sv
// Signal bundle between the Game-of-Life run controller and its surroundings:
// host control, datapath loop (cur_grid -> next_grid) and status outputs.
interface life_run_ctrl_if #(
    parameter int WIDTH = 64,
    parameter int GEN_W = 16
);
    logic [WIDTH-1:0] seed;
    logic             load;
    logic             clear;
    logic             run;
    logic             step;
    logic [GEN_W-1:0] gen_limit;
    logic [WIDTH-1:0] next_grid;
    logic [WIDTH-1:0] cur_grid;
    logic [GEN_W-1:0] gen_count;
    logic             step_en;
    logic             busy;
    logic             done;
    logic             stable;
    logic             extinct;

    modport master (
        output seed, load, clear, run, step, gen_limit, next_grid,
        input  cur_grid, gen_count, step_en, busy, done, stable, extinct
    );

    modport slave (
        input  seed, load, clear, run, step, gen_limit, next_grid,
        output cur_grid, gen_count, step_en, busy, done, stable, extinct
    );
endinterface

// File: rtl/life_run_ctrl.sv
// Sequencer for the 8x8 Life datapath: holds the current grid, advances it at a
// programmable pace or by single steps, and halts on stable/extinct/limit.
module life_run_ctrl #(
    parameter int WIDTH    = 64,
    parameter int TICK_DIV = 4,
    parameter int GEN_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    life_run_ctrl_if.slave    bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PAUSE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [TW-1:0]    tick_reg, tick_next;
    logic [WIDTH-1:0] grid_reg, grid_next;
    logic [GEN_W-1:0] gen_reg, gen_next;
    logic             stable_reg, stable_next;
    logic             extinct_reg, extinct_next;

    logic             update;
    logic [GEN_W-1:0] gen_inc;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            grid_reg    <= '0;
            gen_reg     <= '0;
            stable_reg  <= 1'b0;
            extinct_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            grid_reg    <= grid_next;
            gen_reg     <= gen_next;
            stable_reg  <= stable_next;
            extinct_reg <= extinct_next;
        end
    end

    assign gen_inc = (gen_reg == '1) ? gen_reg : gen_reg + GEN_W'(1);

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        grid_next    = grid_reg;
        gen_next     = gen_reg;
        stable_next  = stable_reg;
        extinct_next = extinct_reg;
        if (bus.clear) begin
            state_next   = IDLE;
            tick_next    = '0;
            grid_next    = '0;
            gen_next     = '0;
            stable_next  = 1'b0;
            extinct_next = 1'b0;
        end else if (bus.load) begin
            state_next   = PAUSE;
            tick_next    = '0;
            grid_next    = bus.seed;
            gen_next     = '0;
            stable_next  = 1'b0;
            extinct_next = 1'b0;
        end else begin
            unique case (state_reg)
                PAUSE: begin
                    if (bus.run) begin
                        state_next = RUN;
                        tick_next  = '0;
                    end
                end
                RUN: begin
                    if (!bus.run) begin
                        state_next = PAUSE;
                        tick_next  = '0;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_next = '0;
                    end else begin
                        tick_next = tick_reg + TW'(1);
                    end
                end
                default: ;
            endcase
            // Halt checks override the RUN/PAUSE transition above
            if (update) begin
                if (bus.next_grid == '0) begin
                    grid_next    = '0;
                    if (grid_reg != '0) gen_next = gen_inc;
                    extinct_next = 1'b1;
                    state_next   = DONE;
                end else if (bus.next_grid == grid_reg) begin
                    stable_next = 1'b1;
                    state_next  = DONE;
                end else begin
                    grid_next = bus.next_grid;
                    gen_next  = gen_inc;
                    if (bus.gen_limit != '0 && gen_inc == bus.gen_limit)
                        state_next = DONE;
                end
            end
        end
    end

    // Decoded outputs
    always_comb begin
        update = 1'b0;
        if (!bus.clear && !bus.load) begin
            if (state_reg == PAUSE && !bus.run && bus.step)
                update = 1'b1;
            else if (state_reg == RUN && bus.run && tick_reg == TICK_LAST)
                update = 1'b1;
        end
    end

    assign bus.step_en   = update;
    assign bus.busy      = (state_reg == RUN);
    assign bus.done      = (state_reg == DONE);
    assign bus.cur_grid  = grid_reg;
    assign bus.gen_count = gen_reg;
    assign bus.stable    = stable_reg;
    assign bus.extinct   = extinct_reg;
endmodule

// File: tb/tb_life_run_ctrl.sv
// Directed plus randomized bench for life_run_ctrl; next_grid comes from a
// golden Life model and all outputs are compared against a behavioural model.
module tb_life_run_ctrl;
    localparam int WIDTH = 64;
    localparam int GEN_W = 16;
    localparam int TDIV  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PAUSE = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    life_run_ctrl_if #(.WIDTH(WIDTH), .GEN_W(GEN_W)) bus ();

    life_run_ctrl #(.WIDTH(WIDTH), .TICK_DIV(TDIV), .GEN_W(GEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                            c + dc >= 0 && c + dc < 8)
                            cnt += int'(g[8*(r+dr) + (c+dc)]);
                n[8*r+c] = (cnt == 3) || (cnt == 2 && g[8*r+c]);
            end
        end
        return n;
    endfunction

    assign bus.next_grid = life_next(bus.cur_grid);

    // Behavioural model
    int          m_mode;
    int          m_run_cycles;
    logic [63:0] m_grid;
    int          m_gen;
    logic        m_stable, m_extinct, m_ev;

    task automatic model_reset();
        m_mode = M_IDLE; m_run_cycles = 0; m_grid = '0; m_gen = 0;
        m_stable = 0; m_extinct = 0;
    endtask

    function automatic int sat_inc(input int v);
        return (v == 65535) ? v : v + 1;
    endfunction

    task automatic model_eval();
        m_ev = 0;
        if (!bus.clear && !bus.load) begin
            if (m_mode == M_PAUSE && bus.step && !bus.run) m_ev = 1;
            if (m_mode == M_RUN && bus.run && (m_run_cycles % TDIV) == TDIV - 1) m_ev = 1;
        end
    endtask

    task automatic model_advance();
        logic [63:0] ng;
        if (bus.clear) begin
            model_reset();
        end else if (bus.load) begin
            model_reset();
            m_grid = bus.seed;
            m_mode = M_PAUSE;
        end else begin
            if (m_mode == M_PAUSE && bus.run) begin
                m_mode = M_RUN; m_run_cycles = 0;
            end else if (m_mode == M_RUN) begin
                if (!bus.run) begin m_mode = M_PAUSE; m_run_cycles = 0; end
                else m_run_cycles++;
            end
            if (m_ev) begin
                ng = life_next(m_grid);
                if (ng == 0) begin
                    if (m_grid != 0) m_gen = sat_inc(m_gen);
                    m_grid = 0; m_extinct = 1; m_mode = M_DONE;
                end else if (ng == m_grid) begin
                    m_stable = 1; m_mode = M_DONE;
                end else begin
                    m_grid = ng; m_gen = sat_inc(m_gen);
                    if (bus.gen_limit != 0 && m_gen == int'(bus.gen_limit)) m_mode = M_DONE;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already applied at the preceding negedge
    task automatic cycle();
        #1;
        model_eval();
        check("step_en", 64'(bus.step_en), 64'(m_ev));
        check("busy_pre", 64'(bus.busy), 64'(m_mode == M_RUN));
        check("done_pre", 64'(bus.done), 64'(m_mode == M_DONE));
        model_advance();
        @(posedge clk); #1;
        check("cur_grid", bus.cur_grid, m_grid);
        check("gen_count", 64'(bus.gen_count), 64'(m_gen));
        check("stable", 64'(bus.stable), 64'(m_stable));
        check("extinct", 64'(bus.extinct), 64'(m_extinct));
        check("busy", 64'(bus.busy), 64'(m_mode == M_RUN));
        check("done", 64'(bus.done), 64'(m_mode == M_DONE));
        @(negedge clk);
    endtask

    task automatic go(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            bus.load = 0; bus.clear = 0; bus.step = 0;
        end
    endtask

    localparam logic [63:0] BLINK_V = 64'h0000_0000_0404_0400;
    localparam logic [63:0] BLINK_H = 64'h0000_0000_000E_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0006_0600;

    initial begin
        bus.seed = '0; bus.load = 0; bus.clear = 0; bus.run = 0; bus.step = 0;
        bus.gen_limit = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 0;
        check("reset_grid", bus.cur_grid, 64'h0);
        check("reset_done", 64'(bus.done), 64'h0);

        // Reset mid-RUN, checked between edges
        bus.seed = BLINK_V; bus.load = 1; go(1);
        bus.run = 1; go(3);
        @(posedge clk); #2;
        reset = 1; #1;
        check("async_grid", bus.cur_grid, 64'h0);
        check("async_busy", 64'(bus.busy), 64'h0);
        check("async_step_en", 64'(bus.step_en), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 0;
        go(6);
        check("idle_ignores_run", 64'(bus.busy), 64'h0);

        // Blinker with limit 4
        bus.run = 0; bus.gen_limit = 4;
        bus.seed = BLINK_V; bus.load = 1; go(1);
        bus.run = 1; go(5);
        check("blink_gen1", bus.cur_grid, BLINK_H);
        go(12);
        check("blink_done", 64'(bus.done), 64'h1);
        check("blink_count", 64'(bus.gen_count), 64'd4);
        check("blink_grid", bus.cur_grid, BLINK_V);
        go(3);

        // Still life
        bus.run = 0; bus.gen_limit = 0;
        bus.seed = BLOCK; bus.load = 1; go(1);
        bus.run = 1; go(5);
        check("block_stable", 64'(bus.stable), 64'h1);
        check("block_count", 64'(bus.gen_count), 64'h0);
        check("block_grid", bus.cur_grid, BLOCK);

        // Extinction by single step
        bus.run = 0;
        bus.seed = 64'h200; bus.load = 1; go(1);
        bus.step = 1; go(1);
        check("ext_grid", bus.cur_grid, 64'h0);
        check("ext_count", 64'(bus.gen_count), 64'd1);
        check("ext_flag", 64'(bus.extinct), 64'h1);
        bus.step = 1; go(1);
        bus.run = 1; go(5);
        check("ext_hold", 64'(bus.done), 64'h1);

        // Pause/resume and collisions
        bus.run = 0;
        bus.seed = BLINK_V; bus.load = 1; go(1);
        bus.run = 1; go(6);
        bus.run = 0; go(1);
        check("pause_count", 64'(bus.gen_count), 64'd1);
        bus.run = 1; bus.step = 1; go(1);
        check("run_wins", 64'(bus.busy), 64'h1);
        check("run_no_update", 64'(bus.gen_count), 64'd1);
        bus.gen_limit = 3; go(9);
        check("limit_done", 64'(bus.done), 64'h1);
        bus.seed = BLINK_V; bus.load = 1; go(1);
        check("load_from_done", 64'(bus.done), 64'h0);
        bus.seed = BLOCK; bus.load = 1; bus.clear = 1; go(1);
        check("clear_over_load", bus.cur_grid, 64'h0);
        go(3);

        // Randomized phase
        bus.gen_limit = 0;
        for (int i = 0; i < 600; i++) begin
            bus.clear = ($urandom_range(0, 59) == 0);
            bus.load  = ($urandom_range(0, 19) == 0);
            bus.seed  = {$urandom, $urandom} & {$urandom, $urandom};
            bus.step  = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 29) == 0) bus.gen_limit = GEN_W'($urandom_range(0, 6));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
